// File: rtl/cc_mem_rd_responder.sv
// Memory-side AXI read responder: queues AR requests, waits a fixed access latency,
// then streams 64-bit beats whose data is a self-describing address pattern.
module cc_mem_rd_responder #(
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [63:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  localparam int unsigned PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = ($clog2(LATENCY + 1) > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned MSK_W = 7;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_e;

  ar_req_t              q_mem_q [REQ_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  state_e               state_q;
  logic [LAT_W-1:0]     lat_q;
  logic [3:0]           id_q;
  logic [31:0]          addr_q;
  logic [3:0]           len_q;
  logic [3:0]           beat_q;
  logic                 err_q;
  logic                 wrap_q;
  logic [MSK_W-1:0]     mask_q;

  logic [3:0]           rid_q;
  logic [63:0]          rdata_q;
  logic [1:0]           rresp_q;
  logic                 rlast_q;
  logic                 rvalid_q;

  logic                 push;
  logic                 pop;
  ar_req_t              push_req;
  ar_req_t              head;
  logic [31:0]          head_aligned;
  logic                 head_wrap_len_ok;
  logic                 head_err;
  logic [MSK_W-1:0]     head_mask;
  logic [31:0]          mask_w;
  logic [31:0]          next_addr_d;
  logic [3:0]           next_beat_d;

  // Beat payload: address and its complement, or zero for an errored request
  function automatic logic [63:0] beat_data(input logic [31:0] a, input logic err);
    if (err) return 64'd0;
    return {~a, a};
  endfunction

  assign arready_o = (count_q != CNT_W'(REQ_DEPTH));
  assign push      = arvalid_i & arready_o;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign push_req  = '{id: arid_i, addr: araddr_i, len: arlen_i, size: arsize_i, burst: arburst_i};
  assign head      = q_mem_q[rd_ptr_q];

  // Decode the queue head into working-register form
  always_comb begin
    head_aligned     = {head.addr[31:3], 3'b000};
    head_wrap_len_ok = (head.len == 4'd1) || (head.len == 4'd3) ||
                       (head.len == 4'd7) || (head.len == 4'd15);
    head_err         = (head.size != 3'b011) ||
                       !((head.burst == BURST_INCR) ||
                         ((head.burst == BURST_WRAP) && head_wrap_len_ok));
    head_mask        = {head.len, 3'b111};
  end

  // Next beat address: wrap keeps the upper bits of the aligned window fixed
  always_comb begin
    mask_w      = 32'(mask_q);
    next_beat_d = 4'(beat_q + 4'd1);
    if (wrap_q) begin
      next_addr_d = (addr_q & ~mask_w) | (32'(addr_q + 32'd8) & mask_w);
    end else begin
      next_addr_d = 32'(addr_q + 32'd8);
    end
  end

  // Request queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REQ_DEPTH); i++) begin
        q_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        q_mem_q[wr_ptr_q] <= push_req;
        wr_ptr_q          <= PTR_W'(wr_ptr_q + PTR_W'(1));
      end
      if (pop) begin
        rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
      end
      unique case ({push, pop})
        2'b10:   count_q <= CNT_W'(count_q + CNT_W'(1));
        2'b01:   count_q <= CNT_W'(count_q - CNT_W'(1));
        default: count_q <= count_q;
      endcase
    end
  end

  // Response FSM with registered R-channel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      mask_q   <= '0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            id_q   <= head.id;
            addr_q <= head_aligned;
            len_q  <= head.len;
            beat_q <= '0;
            err_q  <= head_err;
            wrap_q <= (head.burst == BURST_WRAP);
            mask_q <= head_mask;
            if (LATENCY <= 1) begin
              // Single-cycle latency: the pop cycle itself is the wait
              state_q  <= S_BURST;
              rvalid_q <= 1'b1;
              rid_q    <= head.id;
              rdata_q  <= beat_data(head_aligned, head_err);
              rresp_q  <= head_err ? RESP_SLV : RESP_OKAY;
              rlast_q  <= (head.len == 4'd0);
            end else begin
              state_q <= S_WAIT;
              lat_q   <= LAT_W'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (lat_q == LAT_W'(1)) begin
            state_q  <= S_BURST;
            rvalid_q <= 1'b1;
            rid_q    <= id_q;
            rdata_q  <= beat_data(addr_q, err_q);
            rresp_q  <= err_q ? RESP_SLV : RESP_OKAY;
            rlast_q  <= (len_q == 4'd0);
          end else begin
            lat_q <= LAT_W'(lat_q - LAT_W'(1));
          end
        end
        S_BURST: begin
          if (rvalid_q && rready_i) begin
            if (rlast_q) begin
              state_q  <= S_IDLE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              beat_q  <= next_beat_d;
              addr_q  <= next_addr_d;
              rdata_q <= beat_data(next_addr_d, err_q);
              rlast_q <= (next_beat_d == len_q);
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rid_o    = rid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;
  assign rlast_o  = rlast_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_cc_mem_rd_responder.sv
// Directed bench for cc_mem_rd_responder: wrap/incr addressing, latency, backpressure,
// queue-full behaviour, illegal requests and async reset mid-burst.
`timescale 1ns/1ps
module tb_cc_mem_rd_responder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  arid_i;
  logic [31:0] araddr_i;
  logic [3:0]  arlen_i;
  logic [2:0]  arsize_i;
  logic [1:0]  arburst_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [3:0]  rid_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready_i;

  int n_pass;
  int n_total;

  cc_mem_rd_responder #(.REQ_DEPTH(4), .LATENCY(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arid_i    (arid_i),
    .araddr_i  (araddr_i),
    .arlen_i   (arlen_i),
    .arsize_i  (arsize_i),
    .arburst_i (arburst_i),
    .arvalid_i (arvalid_i),
    .arready_o (arready_o),
    .rid_o     (rid_o),
    .rdata_o   (rdata_o),
    .rresp_o   (rresp_o),
    .rlast_o   (rlast_o),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference beat address straight from the burst definition
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [3:0] len,
                                           input logic [1:0] burst, input int k);
    logic [31:0] start;
    logic [31:0] l;
    start = {a[31:3], 3'b000};
    if (burst == 2'b10) begin
      l = 32'(8 * (int'(len) + 1));
      return (start & ~(l - 32'd1)) | (32'(start + 32'(8 * k)) & (l - 32'd1));
    end
    return 32'(start + 32'(8 * k));
  endfunction

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic rdy;
    bit   done;
    done      = 1'b0;
    arid_i    = id;
    araddr_i  = addr;
    arlen_i   = len;
    arsize_i  = size;
    arburst_i = burst;
    arvalid_i = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      rdy = arready_o;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    arvalid_i = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL ar_handshake id=%0d: arready never seen, required within 50 cycles", id);
    end
  endtask

  // Drains one burst (or the first 'stop' beats); also completes a pending AR if one is driven
  task automatic collect(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic err, input bit toggle,
                         input int stop, output int lat, output logic [63:0] d0);
    int          k;
    int          cyc;
    bit          phase;
    bit          held;
    bit          hs_ar;
    logic        r;
    logic [70:0] snap;
    logic [31:0] ea;
    logic [63:0] ed;
    logic [1:0]  er;
    logic        el;
    k = 0; cyc = 0; phase = 1'b1; held = 1'b0; lat = -1; d0 = '0; snap = '0;
    while (k <= int'(len) && k < stop && cyc < 300) begin
      hs_ar = arvalid_i & arready_o;
      if (rvalid_o) begin
        if (lat < 0) lat = cyc;
        if (held) begin
          n_total++;
          if ({rid_o, rdata_o, rresp_o, rlast_o} !== snap)
            $display("FAIL hold id=%0d beat=%0d: got %h, required held %h", id, k,
                     {rid_o, rdata_o, rresp_o, rlast_o}, snap);
          else n_pass++;
        end
        r = toggle ? phase : 1'b1;
        phase = ~phase;
        rready_i = r;
        if (r) begin
          ea = exp_addr(addr, len, burst, k);
          ed = err ? 64'd0 : {~ea, ea};
          er = err ? 2'b10 : 2'b00;
          el = (k == int'(len));
          n_total++;
          if (rid_o !== id || rdata_o !== ed || rresp_o !== er || rlast_o !== el)
            $display("FAIL beat id=%0d k=%0d: got id=%0d data=%h resp=%0d last=%0b, required id=%0d data=%h resp=%0d last=%0b",
                     id, k, rid_o, rdata_o, rresp_o, rlast_o, id, ed, er, el);
          else n_pass++;
          if (k == 0) d0 = rdata_o;
          k++;
          held = 1'b0;
        end else begin
          snap = {rid_o, rdata_o, rresp_o, rlast_o};
          held = 1'b1;
        end
      end else begin
        rready_i = 1'b0;
        if (k > 0) begin
          n_total++;
          $display("FAIL bubble id=%0d k=%0d: rvalid=0 mid-burst, required 1", id, k);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (hs_ar) arvalid_i = 1'b0;
    end
    rready_i = 1'b0;
    if (k <= int'(len) && k < stop) begin
      n_total++;
      $display("FAIL burst_timeout id=%0d: got %0d beats, required %0d", id, k, int'(len) + 1);
    end
  endtask

  task automatic check_idle_after(input string name);
    n_total++;
    if (rvalid_o !== 1'b0) $display("FAIL %s: rvalid=%0b after last beat, required 0", name, rvalid_o);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({rvalid_o, rlast_o, rid_o, rdata_o, rresp_o} !== 72'd0)
      $display("FAIL reset_outputs: got v=%0b l=%0b id=%0d d=%h r=%0d, required all 0",
               rvalid_o, rlast_o, rid_o, rdata_o, rresp_o);
    else n_pass++;
    n_total++;
    if (arready_o !== 1'b1) $display("FAIL reset_arready: got %0b, required 1", arready_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (rvalid_o !== 1'b0 || arready_o !== 1'b1)
      $display("FAIL post_reset: got rvalid=%0b arready=%0b, required 0/1", rvalid_o, arready_o);
    else n_pass++;
  endtask

  task automatic test_wrap_fill();
    int lat;
    logic [63:0] d0;
    send_ar(4'd3, 32'h1000_0028, 4'd7, 3'b011, 2'b10);
    collect(4'd3, 32'h1000_0028, 4'd7, 2'b10, 1'b0, 1'b0, 99, lat, d0);
    n_total++;
    if (lat !== 4) $display("FAIL wrap_latency: first rvalid %0d cycles after AR+1, required 4", lat);
    else n_pass++;
    n_total++;
    if (d0 !== 64'hEFFF_FFD7_1000_0028) $display("FAIL wrap_beat0: got %h, required efffffd710000028", d0);
    else n_pass++;
    check_idle_after("wrap_end");
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] d0;
    send_ar(4'd3, 32'h1000_0028, 4'd7, 3'b011, 2'b10);
    collect(4'd3, 32'h1000_0028, 4'd7, 2'b10, 1'b0, 1'b1, 99, lat, d0);
    check_idle_after("bp_end");
  endtask

  task automatic test_queue_full();
    int lat;
    logic [63:0] d0;
    rready_i = 1'b0;
    for (int i = 0; i < 5; i++)
      send_ar(4'(i), 32'h3000_0100 + 32'(i * 24), 4'd7, 3'b011, 2'b10);
    n_total++;
    if (arready_o !== 1'b0) $display("FAIL queue_full: arready=%0b with 5 outstanding, required 0", arready_o);
    else n_pass++;
    arid_i    = 4'd5;
    araddr_i  = 32'h3000_0100 + 32'(5 * 24);
    arlen_i   = 4'd7;
    arsize_i  = 3'b011;
    arburst_i = 2'b10;
    arvalid_i = 1'b1;
    for (int i = 0; i < 6; i++)
      collect(4'(i), 32'h3000_0100 + 32'(i * 24), 4'd7, 2'b10, 1'b0, 1'b0, 99, lat, d0);
    arvalid_i = 1'b0;
    check_idle_after("queue_end");
  endtask

  task automatic test_incr();
    int lat;
    logic [63:0] d0;
    send_ar(4'd9, 32'h2000_0010, 4'd3, 3'b011, 2'b01);
    collect(4'd9, 32'h2000_0010, 4'd3, 2'b01, 1'b0, 1'b0, 99, lat, d0);
    n_total++;
    if (d0 !== 64'hDFFF_FFEF_2000_0010) $display("FAIL incr_beat0: got %h, required dfffffef20000010", d0);
    else n_pass++;
    check_idle_after("incr_end");
  endtask

  task automatic test_illegal();
    int lat;
    logic [63:0] d0;
    send_ar(4'd6, 32'h4000_0008, 4'd7, 3'b010, 2'b10);
    collect(4'd6, 32'h4000_0008, 4'd7, 2'b10, 1'b1, 1'b0, 99, lat, d0);
    check_idle_after("bad_size_end");
    send_ar(4'd12, 32'h4000_0040, 4'd0, 3'b011, 2'b00);
    collect(4'd12, 32'h4000_0040, 4'd0, 2'b00, 1'b1, 1'b0, 99, lat, d0);
    check_idle_after("fixed_end");
  endtask

  task automatic test_reset_mid_burst();
    int lat;
    logic [63:0] d0;
    send_ar(4'd3, 32'h1000_0028, 4'd7, 3'b011, 2'b10);
    collect(4'd3, 32'h1000_0028, 4'd7, 2'b10, 1'b0, 1'b0, 3, lat, d0);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rvalid_o !== 1'b0 || arready_o !== 1'b1)
      $display("FAIL midburst_reset: got rvalid=%0b arready=%0b, required 0/1", rvalid_o, arready_o);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_ar(4'd10, 32'h5000_0010, 4'd7, 3'b011, 2'b10);
    collect(4'd10, 32'h5000_0010, 4'd7, 2'b10, 1'b0, 1'b0, 99, lat, d0);
    n_total++;
    if (lat !== 4) $display("FAIL reset_relatency: first rvalid %0d cycles after AR+1, required 4", lat);
    else n_pass++;
    check_idle_after("reset_end");
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    arid_i    = '0;
    araddr_i  = '0;
    arlen_i   = '0;
    arsize_i  = '0;
    arburst_i = '0;
    arvalid_i = 1'b0;
    rready_i  = 1'b0;
    #1;
    test_reset();
    test_wrap_fill();
    test_backpressure();
    test_queue_full();
    test_incr();
    test_illegal();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
